// File: rtl/ex_pkg.sv
// ex_pkg: shared widths, branch-kind encodings and the condition-code flag triple.
package ex_pkg;
    localparam int DW = 16;
    localparam int RW = 3;
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQZ = 3'b001;
    localparam logic [2:0] BR_BNEZ = 3'b010;
    localparam logic [2:0] BR_BLTZ = 3'b011;
    localparam logic [2:0] BR_BGEZ = 3'b100;
    localparam logic [2:0] BR_JUMP = 3'b101;
    localparam logic [2:0] BR_BOV  = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;
    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;
endpackage

// File: rtl/ex_mem_stage_br_cond.sv
// br_cond: branch-taken decision from the branch kind, ALU flags and the committed overflow flag.
module br_cond
    import ex_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic       z,
    input  logic       n,
    input  logic       cc_v,
    output logic       taken
);
    always_comb begin
        taken = (br_type == BR_BEQZ) ? z :
                (br_type == BR_BNEZ) ? ~z :
                (br_type == BR_BLTZ) ? n :
                (br_type == BR_BGEZ) ? ~n :
                (br_type == BR_JUMP) ? 1'b1 :
                (br_type == BR_BOV)  ? cc_v : 1'b0;
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with condition-code register and one-cycle branch redirect.
module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int DW = ex_pkg::DW,
    parameter int RW = ex_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_out,
    input  logic          z,
    input  logic          v,
    input  logic          n,
    input  logic          set_flags,
    input  logic [2:0]    br_type,
    input  logic [DW-1:0] br_target,
    input  logic [DW-1:0] pc_plus2,
    input  logic          link,
    input  logic [RW-1:0] rd,
    input  logic          reg_we,
    input  logic          mem_re,
    input  logic          mem_we,
    input  logic [DW-1:0] store_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_we,
    output logic          out_mem_re,
    output logic          out_mem_we,
    output logic [DW-1:0] out_store_data,
    output logic          cc_z,
    output logic          cc_v,
    output logic          cc_n,
    output logic          redirect_valid,
    output logic [DW-1:0] redirect_pc
);
    flags_t cc;
    logic   accept;
    logic   taken;

    assign in_ready = ~out_valid | out_ready;
    // Anything offered during a redirect cycle is wrong-path and silently dropped.
    assign accept   = in_valid & in_ready & ~flush & ~redirect_valid;
    assign {cc_z, cc_v, cc_n} = cc;

    br_cond u_br_cond (
        .br_type (br_type),
        .z       (z),
        .n       (n),
        .cc_v    (cc.v),
        .taken   (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_rd         <= '0;
            out_reg_we     <= 1'b0;
            out_mem_re     <= 1'b0;
            out_mem_we     <= 1'b0;
            out_store_data <= '0;
            cc             <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & taken;
            if (accept & taken)
                redirect_pc <= br_target;
            if (accept & set_flags)
                cc <= '{z: z, v: v, n: n};
            if (accept) begin
                out_valid      <= 1'b1;
                out_result     <= link ? pc_plus2 : alu_out;
                out_rd         <= rd;
                out_reg_we     <= reg_we;
                out_mem_re     <= mem_re;
                out_mem_we     <= mem_we;
                out_store_data <= store_data;
            end else if (flush | out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors with hand-computed expectations for ex_mem_stage.
module tb_ex_mem_stage;
    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, z, v, n, set_flags, link;
    logic          reg_we, mem_re, mem_we, flush, out_valid, out_ready;
    logic [2:0]    br_type;
    logic [DW-1:0] alu_out, br_target, pc_plus2, store_data, out_result, out_store_data, redirect_pc;
    logic [RW-1:0] rd, out_rd;
    logic          out_reg_we, out_mem_re, out_mem_we, cc_z, cc_v, cc_n, redirect_valid;
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .z(z), .v(v), .n(n), .set_flags(set_flags),
        .br_type(br_type), .br_target(br_target), .pc_plus2(pc_plus2), .link(link),
        .rd(rd), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
        .store_data(store_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_reg_we(out_reg_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
        .out_store_data(out_store_data), .cc_z(cc_z), .cc_v(cc_v), .cc_n(cc_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 0; z = 0; v = 0; n = 0; set_flags = 0; link = 0;
        reg_we = 0; mem_re = 0; mem_we = 0; flush = 0; out_ready = 1;
        br_type = 3'b000; alu_out = '0; br_target = '0; pc_plus2 = '0; store_data = '0; rd = '0;
        step(); step();
        rst = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_redirect", redirect_valid, 0);
        check("rst_cc", {cc_z, cc_v, cc_n}, 3'b000);
        check("rst_result", out_result, 0);
        check("rst_in_ready", in_ready, 1);

        in_valid = 1; alu_out = 16'h1234; reg_we = 1; rd = 3; mem_we = 1; store_data = 16'hABCD;
        step();
        check("t1_valid", out_valid, 1);
        check("t1_result", out_result, 16'h1234);
        check("t1_rd", out_rd, 3);
        check("t1_reg_we", out_reg_we, 1);
        check("t1_mem_we", out_mem_we, 1);
        check("t1_store", out_store_data, 16'hABCD);
        check("t1_cc", {cc_z, cc_v, cc_n}, 3'b000);

        out_ready = 0; alu_out = 16'h5555; rd = 5; mem_we = 0; store_data = 16'h0000;
        #1;
        check("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", out_valid, 1);
            check("stall_result", out_result, 16'h1234);
            check("stall_rd", out_rd, 3);
        end
        out_ready = 1;
        #1;
        check("release_in_ready", in_ready, 1);
        step();
        in_valid = 0;
        check("release_result", out_result, 16'h5555);
        check("release_rd", out_rd, 5);
        check("release_mem_we", out_mem_we, 0);
        step();
        check("drain_valid", out_valid, 0);

        in_valid = 1; br_type = 3'b001; z = 1; br_target = 16'h0040; alu_out = 16'h0000; reg_we = 0; rd = 0;
        step();
        check("beqz_redirect", redirect_valid, 1);
        check("beqz_pc", redirect_pc, 16'h0040);
        check("beqz_valid", out_valid, 1);
        br_type = 3'b000; z = 0; alu_out = 16'hDEAD;
        #1;
        check("redir_in_ready", in_ready, 1);
        step();
        in_valid = 0;
        check("redir_pulse_end", redirect_valid, 0);
        check("wrong_path_dropped", out_valid, 0);
        check("wrong_path_result", out_result, 16'h0000);

        in_valid = 1; set_flags = 1; v = 1; alu_out = 16'h0001;
        step();
        check("setv_cc", {cc_z, cc_v, cc_n}, 3'b010);
        check("setv_redirect", redirect_valid, 0);
        br_type = 3'b110; v = 0; br_target = 16'h0080;
        step();
        in_valid = 0; br_type = 3'b000; set_flags = 0;
        check("bov_redirect", redirect_valid, 1);
        check("bov_pc", redirect_pc, 16'h0080);
        check("bov_cc_v", cc_v, 0);
        step();
        check("bov_pulse_end", redirect_valid, 0);

        in_valid = 1; set_flags = 1; z = 1; v = 0; n = 1; alu_out = 16'h0007;
        step();
        check("setzn_cc", {cc_z, cc_v, cc_n}, 3'b101);
        flush = 1; br_type = 3'b101; z = 0; v = 1; n = 0; br_target = 16'h0100;
        step();
        flush = 0; in_valid = 0; br_type = 3'b000; set_flags = 0;
        check("flush_valid", out_valid, 0);
        check("flush_redirect", redirect_valid, 0);
        check("flush_cc", {cc_z, cc_v, cc_n}, 3'b101);

        in_valid = 1; br_type = 3'b010; z = 1;
        step();
        check("bnez_nt", redirect_valid, 0);
        br_type = 3'b111; z = 0;
        step();
        check("rsvd_nt", redirect_valid, 0);
        br_type = 3'b100; n = 0; br_target = 16'h0200;
        step();
        check("bgez_taken", redirect_valid, 1);
        check("bgez_pc", redirect_pc, 16'h0200);
        br_type = 3'b000;
        step();

        link = 1; pc_plus2 = 16'h0102; alu_out = 16'hFFFF; reg_we = 1; rd = 7;
        step();
        in_valid = 0; link = 0;
        check("link_result", out_result, 16'h0102);
        check("link_rd", out_rd, 7);
        out_ready = 0;
        step();
        check("stall2_valid", out_valid, 1);
        rst = 1;
        step();
        rst = 0;
        check("rst2_valid", out_valid, 0);
        check("rst2_result", out_result, 0);
        check("rst2_rd", out_rd, 0);
        check("rst2_reg_we", out_reg_we, 0);
        check("rst2_cc", {cc_z, cc_v, cc_n}, 3'b000);
        check("rst2_redirect", redirect_valid, 0);
        check("rst2_in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Pipeline stage directly downstream of the 16-bit ALU. It registers the ALU result and z/v/n flags, together with the instruction's control bits, into the EX/MEM boundary. It also holds the architectural condition-code register and resolves branches, producing a one-cycle PC redirect. Upstream and downstream handshakes use valid/ready with backpressure and flush.

Parameters:
DW, 16, datapath width (result, PC, store data)
RW, 3, register-specifier width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream holds a valid executed instruction
in_ready  out  1  stage can accept this cycle
alu_out  in  DW  ALU result
z, v, n  in  1  ALU flags for this instruction
set_flags  in  1  instruction writes condition-code register
br_type  in  3  branch kind (see Behaviour)
br_target  in  DW  taken-branch target PC
pc_plus2  in  DW  PC of instruction + 2
link  in  1  result becomes pc_plus2 (jump-and-link)
rd  in  RW  destination register
reg_we, mem_re, mem_we  in  1  control bits carried forward
store_data  in  DW  store operand
flush  in  1  kill incoming instruction and current stage contents
out_valid  out  1  stage register holds a valid instruction
out_ready  in  1  downstream accepts
out_result  out  DW  alu_out, or pc_plus2 when link=1
out_rd, out_reg_we, out_mem_re, out_mem_we, out_store_data  out  -  registered copies
cc_z, cc_v, cc_n  out  1  condition-code register
redirect_valid  out  1  one-cycle pulse: taken branch
redirect_pc  out  DW  target, valid only with redirect_valid

Behaviour:
- Reset (synchronous, rst=1 at edge): out_valid=0, redirect_valid=0, cc_z/v/n=0, all data outputs 0. rst overrides flush and accept; reset mid-stall drops the held instruction.
- in_ready = ~out_valid | out_ready (combinational). accept = in_valid & in_ready & ~flush & ~redirect_valid.
- Latency is 1 cycle: an instruction accepted at edge k appears on the outputs after edge k.
- Stall (out_valid & ~out_ready): all out_* values and the cc register hold. in_ready=0.
- Drain with no accept (out_ready=1, no accept): out_valid -> 0.
- flush=1: out_valid -> 0 next edge. The incoming instruction is discarded: no cc update, no redirect.
- br_type: 000 none; 001 BEQZ taken if z; 010 BNEZ taken if ~z; 011 BLTZ taken if n; 100 BGEZ taken if ~n; 101 JUMP always; 110 BOV taken if cc_v (register value before this instruction's update); 111 reserved, treated as none.
- Taken branch on accept: redirect_valid=1 and redirect_pc=br_target for exactly the next cycle. The branch also enters the stage normally.
- Redirect cycle (redirect_valid=1): in_valid is treated as wrong-path. It is not accepted, and in_ready still reflects the formula so upstream drops it. redirect_valid clears after one cycle regardless of stalls.
- cc register: on accept with set_flags=1, cc <= {z,v,n}. Otherwise it holds. Flushed or rejected instructions never update cc.
- Simultaneous accept of BOV with set_flags=1: the branch uses the old cc_v, and cc is updated afterwards.
- out_result = link ? pc_plus2 : alu_out, captured at accept. Widths are exact DW with no extension.

Decomposition:
- Shared package ex_pkg: BR_NONE..BR_RSVD 3-bit constants; DW/RW defaults; packed flag triple type {z,v,n}.
- One natural sub-module: br_cond. It is combinational and takes br_type, z, n, cc_v, returning taken.

Test Plan:
- Reset, then alu_out=16'h1234, reg_we=1, rd=3, accept -> next cycle out_valid=1, out_result=16'h1234, out_rd=3; cc stays 000.
- Stall: out_ready=0 for 3 cycles with new in_valid present -> in_ready=0, outputs frozen at the prior instruction; release -> new instruction appears 1 cycle later.
- BEQZ with z=1, br_target=16'h0040 -> redirect_valid high for exactly 1 cycle with redirect_pc=16'h0040. in_valid in that cycle is dropped (never reaches out_valid).
- set_flags=1 with v=1, then BOV with set_flags=1 and v=0 -> BOV taken (old cc_v=1), and cc_v=0 afterwards.
- flush asserted with an incoming taken JUMP and set_flags=1 -> no redirect, cc unchanged, out_valid=0 next cycle.
- link=1, pc_plus2=16'h0102, alu_out=16'hFFFF -> out_result=16'h0102. Asserting rst while stalled -> all outputs 0 after the edge.
